// File: rtl/intc_pkg.sv
// -----------------------------------------------------------------------------
// intc_pkg
// Shared definitions for the interrupt controller slice:
//   - default source count and vector geometry
//   - FSM state encoding {IDLE, REQ}
//   - handler vector address helper
// Optional feature macro used by this slice: INTC_NESTING_EN
// -----------------------------------------------------------------------------
package intc_pkg;

    localparam int          INTC_NUM_SRC       = 3;
    localparam int          INTC_SRC_W         = (INTC_NUM_SRC > 1) ? $clog2(INTC_NUM_SRC) : 1;
    localparam int          INTC_VEC_W         = 32;
    localparam logic [31:0] INTC_VECTOR_BASE   = 32'h0000_0100;
    localparam logic [31:0] INTC_VECTOR_STRIDE = 32'h0000_0010;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } intc_state_e;

    // Handler address of source idx: base + idx * stride.
    function automatic logic [INTC_VEC_W-1:0] intc_vec_addr(
        input logic [INTC_VEC_W-1:0] base,
        input logic [INTC_VEC_W-1:0] stride,
        input logic [INTC_VEC_W-1:0] idx
    );
        return base + (idx * stride);
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// -----------------------------------------------------------------------------
// interrupt_controller_if
// Request/acknowledge handshake between the interrupt controller and the CPU.
//   intRequest  controller -> CPU   interrupt pending
//   intSource   controller -> CPU   index of presented source
//   intVector   controller -> CPU   handler address of presented source
//   intAck      CPU -> controller   accept presented interrupt (1-cycle pulse)
//   eret        CPU -> controller   return from handler (1-cycle pulse)
// Modports: master = CPU side, slave = controller side.
// Optional feature macro of this slice: INTC_NESTING_EN (not used here)
// -----------------------------------------------------------------------------
interface interrupt_controller_if #(
    parameter int SRC_W = intc_pkg::INTC_SRC_W,
    parameter int VEC_W = intc_pkg::INTC_VEC_W
);
    logic             intRequest;
    logic [SRC_W-1:0] intSource;
    logic [VEC_W-1:0] intVector;
    logic             intAck;
    logic             eret;

    modport master (
        input  intRequest,
        input  intSource,
        input  intVector,
        output intAck,
        output eret
    );

    modport slave (
        output intRequest,
        output intSource,
        output intVector,
        input  intAck,
        input  eret
    );
endinterface

// File: rtl/intc_priority_encoder.sv
// -----------------------------------------------------------------------------
// intc_priority_encoder
// Combinational highest-set-bit encoder.
//   req_i    in  N  request vector
//   idx_o    out W  index of the highest set bit (0 when none set)
//   valid_o  out 1  at least one bit set
// Optional feature macro of this slice: INTC_NESTING_EN (not used here)
// -----------------------------------------------------------------------------
module intc_priority_encoder #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    // Scan upward so the highest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        for (int i = 0; i < N; i++) begin
            idx_o = req_i[i] ? W'(i) : idx_o;
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
// Edge-captures NUM_SRC interrupt lines, applies per-source mask and a global
// enable, presents the highest-priority eligible source to the CPU through a
// request/ack handshake, and tracks in-service sources.
// Ports:
//   clock      in   system clock
//   reset      in   synchronous active-high reset
//   irqIn      in   raw (synchronised) interrupt levels
//   maskWe     in   load mask register from maskData
//   maskData   in   new mask, 1 = source enabled
//   ieSet      in   set global enable
//   ieClear    in   clear global enable (wins over ieSet)
//   bus        slave modport: intRequest/intSource/intVector out, intAck/eret in
//   inService  out  sources currently being handled
//   ie         out  global enable
// Macro INTC_NESTING_EN: when defined a higher-priority source may preempt a
// lower one in service; when undefined only one source is ever in service and
// eret clears all in-service bits.
// -----------------------------------------------------------------------------
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int               NUM_SRC       = INTC_NUM_SRC,
    parameter int               VEC_W         = INTC_VEC_W,
    parameter logic [VEC_W-1:0] VECTOR_BASE   = VEC_W'(INTC_VECTOR_BASE),
    parameter logic [VEC_W-1:0] VECTOR_STRIDE = VEC_W'(INTC_VECTOR_STRIDE)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_SRC-1:0]    irqIn,
    input  logic                  maskWe,
    input  logic [NUM_SRC-1:0]    maskData,
    input  logic                  ieSet,
    input  logic                  ieClear,
    interrupt_controller_if.slave bus,
    output logic [NUM_SRC-1:0]    inService,
    output logic                  ie
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    intc_state_e      state_q;
    logic [NUM_SRC-1:0] prev_irq_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] in_service_q;
    logic [NUM_SRC-1:0] in_service_d;
    logic               ie_q;
    logic               ie_d;
    logic               int_request_q;
    logic [SRC_W-1:0]   int_source_q;
    logic [VEC_W-1:0]   int_vector_q;

    logic               ack_s;
    logic [NUM_SRC-1:0] ack_onehot_s;
    logic [NUM_SRC-1:0] eret_clr_s;
    logic [NUM_SRC-1:0] above_svc_s;
    logic [NUM_SRC-1:0] eligible_s;
    logic [SRC_W-1:0]   sel_s;
    logic               sel_valid_s;
    logic [SRC_W-1:0]   svc_hi_s;
    logic               svc_valid_s;
    logic [VEC_W-1:0]   sel_vector_s;

    intc_priority_encoder #(.N(NUM_SRC), .W(SRC_W)) u_sel_enc (
        .req_i   (eligible_s),
        .idx_o   (sel_s),
        .valid_o (sel_valid_s)
    );

    intc_priority_encoder #(.N(NUM_SRC), .W(SRC_W)) u_svc_enc (
        .req_i   (in_service_q),
        .idx_o   (svc_hi_s),
        .valid_o (svc_valid_s)
    );

    // Eligibility, ack/eret side effects and next values of pending/inService/ie.
    always_comb begin
        ack_s        = (state_q == REQ) && bus.intAck;
        ack_onehot_s = '0;
        eret_clr_s   = '0;
        above_svc_s  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_onehot_s[i] = ack_s && (int_source_q == SRC_W'(i));
`ifdef INTC_NESTING_EN
            above_svc_s[i] = !svc_valid_s || (SRC_W'(i) > svc_hi_s);
            eret_clr_s[i]  = bus.eret && svc_valid_s && (SRC_W'(i) == svc_hi_s);
`else
            above_svc_s[i] = !svc_valid_s;
            // At most one bit is ever set, so clearing everything at or below
            // the highest set bit clears the whole vector.
            eret_clr_s[i]  = bus.eret && svc_valid_s && (SRC_W'(i) <= svc_hi_s);
`endif
        end
        eligible_s   = pending_q & mask_q & above_svc_s;
        // A new edge on the acked source keeps it pending (set wins).
        pending_d    = (pending_q & ~ack_onehot_s) | (irqIn & ~prev_irq_q);
        in_service_d = (in_service_q & ~eret_clr_s) | ack_onehot_s;
        if (ack_s || ieClear) begin
            ie_d = 1'b0;
        end else if (ieSet || bus.eret) begin
            ie_d = 1'b1;
        end else begin
            ie_d = ie_q;
        end
        sel_vector_s = VEC_W'(intc_vec_addr(INTC_VEC_W'(VECTOR_BASE),
                                            INTC_VEC_W'(VECTOR_STRIDE),
                                            INTC_VEC_W'(sel_s)));
    end

    // State registers and request FSM with registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            prev_irq_q    <= irqIn;
            pending_q     <= '0;
            mask_q        <= '1;
            in_service_q  <= '0;
            ie_q          <= 1'b1;
            int_request_q <= 1'b0;
            int_source_q  <= '0;
            int_vector_q  <= VECTOR_BASE;
        end else begin
            prev_irq_q   <= irqIn;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            ie_q         <= ie_d;
            if (maskWe) begin
                mask_q <= maskData;
            end else begin
                mask_q <= mask_q;
            end
            case (state_q)
                IDLE: begin
                    if (ie_q && sel_valid_s) begin
                        state_q       <= REQ;
                        int_request_q <= 1'b1;
                        int_source_q  <= sel_s;
                        int_vector_q  <= sel_vector_s;
                    end else begin
                        state_q       <= IDLE;
                        int_request_q <= 1'b0;
                    end
                end
                REQ: begin
                    if (bus.intAck) begin
                        state_q       <= IDLE;
                        int_request_q <= 1'b0;
                    end else if (ie_q && sel_valid_s) begin
                        // Retarget so a higher-priority arrival wins before ack.
                        state_q       <= REQ;
                        int_request_q <= 1'b1;
                        int_source_q  <= sel_s;
                        int_vector_q  <= sel_vector_s;
                    end else begin
                        state_q       <= IDLE;
                        int_request_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    int_request_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.intRequest = int_request_q;
    assign bus.intSource  = int_source_q;
    assign bus.intVector  = int_vector_q;
    assign inService      = in_service_q;
    assign ie             = ie_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
// Directed scenarios followed by randomized stimulus, every cycle compared
// against a behavioural model of the controller kept in this bench.
// Honours INTC_NESTING_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] irqIn;
    logic       maskWe;
    logic [2:0] maskData;
    logic       ieSet;
    logic       ieClear;
    logic [2:0] inService;
    logic       ie;

    interrupt_controller_if #(.SRC_W(2), .VEC_W(32)) intc_if();

    interrupt_controller dut (
        .clock     (clock),
        .reset     (reset),
        .irqIn     (irqIn),
        .maskWe    (maskWe),
        .maskData  (maskData),
        .ieSet     (ieSet),
        .ieClear   (ieClear),
        .bus       (intc_if.slave),
        .inService (inService),
        .ie        (ie)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model state: plain arrays and integers.
    bit m_pend [3];
    bit m_mask [3];
    bit m_svc  [3];
    bit m_prev [3];
    bit m_ie;
    bit m_req;
    int m_src;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock of behaviour, applied from the inputs present at the edge.
    task automatic model_step();
        int  hi;
        int  best;
        int  acked;
        bit  ok;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_pend[i] = 1'b0;
                m_svc[i]  = 1'b0;
                m_mask[i] = 1'b1;
                m_prev[i] = irqIn[i];
            end
            m_ie  = 1'b1;
            m_req = 1'b0;
            m_src = 0;
            return;
        end
        hi = -1;
        for (int i = 0; i < 3; i++) if (m_svc[i]) hi = i;
        best = -1;
        for (int i = 0; i < 3; i++) begin
`ifdef INTC_NESTING_EN
            ok = (i > hi);
`else
            ok = (hi < 0);
`endif
            if (m_pend[i] && m_mask[i] && ok) best = i;
        end
        acked = -1;
        if (m_req) begin
            if (intc_if.intAck) begin
                acked = m_src;
                m_req = 1'b0;
            end else if (m_ie && best >= 0) begin
                m_src = best;
            end else begin
                m_req = 1'b0;
            end
        end else if (m_ie && best >= 0) begin
            m_req = 1'b1;
            m_src = best;
        end
        if (intc_if.eret && hi >= 0) begin
`ifdef INTC_NESTING_EN
            m_svc[hi] = 1'b0;
`else
            for (int i = 0; i < 3; i++) m_svc[i] = 1'b0;
`endif
        end
        if (acked >= 0) begin
            m_svc[acked]  = 1'b1;
            m_pend[acked] = 1'b0;
            m_ie = 1'b0;
        end else if (ieClear) begin
            m_ie = 1'b0;
        end else if (ieSet || intc_if.eret) begin
            m_ie = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            if (irqIn[i] && !m_prev[i]) m_pend[i] = 1'b1;
            m_prev[i] = irqIn[i];
        end
        if (maskWe) for (int i = 0; i < 3; i++) m_mask[i] = maskData[i];
    endtask

    task automatic tick();
        logic [2:0] svc;
        @(posedge clock);
        model_step();
        #1;
        for (int i = 0; i < 3; i++) svc[i] = m_svc[i];
        check("intRequest", 32'(intc_if.intRequest), 32'(m_req));
        check("intSource",  32'(intc_if.intSource),  32'(m_src));
        check("intVector",  intc_if.intVector,       32'(256 + m_src * 16));
        check("inService",  32'(inService),          32'(svc));
        check("ie",         32'(ie),                 32'(m_ie));
    endtask

    task automatic clear_pulses();
        maskWe         = 1'b0;
        ieSet          = 1'b0;
        ieClear        = 1'b0;
        intc_if.intAck = 1'b0;
        intc_if.eret   = 1'b0;
    endtask

    task automatic do_reset(input logic [2:0] lines);
        irqIn = lines;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        clear_pulses();
        maskData = 3'b000;

        // Line held high through reset never requests; a fresh edge does.
        do_reset(3'b010);
        repeat (4) tick();
        check("held_no_req", 32'(intc_if.intRequest), 32'd0);
        irqIn = 3'b000; tick();
        irqIn = 3'b010; tick();
        check("k_no_req_yet", 32'(intc_if.intRequest), 32'd0);
        tick();
        check("edge_req", 32'(intc_if.intRequest), 32'd1);
        check("edge_src", 32'(intc_if.intSource), 32'd1);
        check("edge_vec", intc_if.intVector, 32'h0000_0110);

        // Retarget to a higher-priority arrival before ack.
        do_reset(3'b000);
        irqIn = 3'b001; tick(); tick();
        irqIn = 3'b101; tick(); tick();
        check("retarget_src", 32'(intc_if.intSource), 32'd2);
        check("retarget_vec", intc_if.intVector, 32'h0000_0120);
        intc_if.intAck = 1'b1; tick(); intc_if.intAck = 1'b0;
        check("ack_svc", 32'(inService), 32'b100);
        check("ack_ie", 32'(ie), 32'd0);
        intc_if.eret = 1'b1; tick(); intc_if.eret = 1'b0;
        tick();
        check("src0_left_pending", 32'(intc_if.intSource), 32'd0);

        // Nesting: src0 in service, then src2 arrives.
        intc_if.intAck = 1'b1; tick(); intc_if.intAck = 1'b0;
        ieSet = 1'b1; tick(); ieSet = 1'b0;
        irqIn = 3'b001; tick();
        irqIn = 3'b101; tick(); tick();
`ifdef INTC_NESTING_EN
        check("nest_req", 32'(intc_if.intRequest), 32'd1);
        check("nest_src", 32'(intc_if.intSource), 32'd2);
        intc_if.intAck = 1'b1; tick(); intc_if.intAck = 1'b0;
        check("nest_svc", 32'(inService), 32'b101);
        intc_if.eret = 1'b1; tick();
        check("nest_eret_svc", 32'(inService), 32'b001);
        check("nest_eret_ie", 32'(ie), 32'd1);
        tick(); intc_if.eret = 1'b0;
`else
        check("flat_no_req", 32'(intc_if.intRequest), 32'd0);
        intc_if.eret = 1'b1; tick(); intc_if.eret = 1'b0;
        check("flat_eret_svc", 32'(inService), 32'b000);
        check("flat_eret_ie", 32'(ie), 32'd1);
        tick();
        check("flat_req_after", 32'(intc_if.intSource), 32'd2);
        intc_if.intAck = 1'b1; tick(); intc_if.intAck = 1'b0;
        intc_if.eret = 1'b1; tick(); intc_if.eret = 1'b0;
`endif

        // Mask retains a pending source until unmasked.
        do_reset(3'b000);
        maskWe = 1'b1; maskData = 3'b110; tick(); maskWe = 1'b0;
        irqIn = 3'b001; tick(); tick(); tick();
        check("masked_no_req", 32'(intc_if.intRequest), 32'd0);
        maskWe = 1'b1; maskData = 3'b111; tick(); maskWe = 1'b0;
        tick();
        check("unmask_req", 32'(intc_if.intRequest), 32'd1);
        check("unmask_src", 32'(intc_if.intSource), 32'd0);

        // Ack in IDLE ignored; ieSet with ieClear leaves ie clear.
        do_reset(3'b000);
        intc_if.intAck = 1'b1; ieSet = 1'b1; ieClear = 1'b1; tick(); clear_pulses();
        check("idle_ack_ie", 32'(ie), 32'd0);
        check("idle_ack_svc", 32'(inService), 32'd0);
        check("idle_ack_req", 32'(intc_if.intRequest), 32'd0);

        // Reset during a request.
        do_reset(3'b000);
        irqIn = 3'b011; tick(); tick();
        check("pre_reset_req", 32'(intc_if.intRequest), 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_req", 32'(intc_if.intRequest), 32'd0);
        check("rst_src", 32'(intc_if.intSource), 32'd0);
        check("rst_vec", intc_if.intVector, 32'h0000_0100);
        check("rst_ie", 32'(ie), 32'd1);
        tick(); tick();
        check("rst_held_no_req", 32'(intc_if.intRequest), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) == 0) irqIn = 3'($urandom);
            intc_if.intAck = ($urandom_range(0, 3) == 0);
            intc_if.eret   = ($urandom_range(0, 7) == 0);
            ieSet          = ($urandom_range(0, 7) == 0);
            ieClear        = ($urandom_range(0, 15) == 0);
            maskWe         = ($urandom_range(0, 15) == 0);
            maskData       = 3'($urandom);
            reset          = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
